// File: rtl/vcfu_pkg.sv
// Shared definitions for the vector CFU command sequencer: opcodes, FSM
// states, BUS mux encodings and command field positions.
package vcfu_pkg;

  // funct3 opcodes carried in cmd_payload_function_id[2:0]
  localparam logic [2:0] OP_VSET    = 3'd0;
  localparam logic [2:0] OP_ALU_VV  = 3'd1;
  localparam logic [2:0] OP_ALU_VI  = 3'd2;
  localparam logic [2:0] OP_VMUL    = 3'd3;
  localparam logic [2:0] OP_VREDSUM = 3'd4;
  localparam logic [2:0] OP_NOP     = 3'd5;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // BUS mux select encodings
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_ALU  = 2'b01;
  localparam logic [1:0] BUS_MUL  = 2'b10;
  localparam logic [1:0] BUS_ACC  = 2'b11;

  // Largest legal register group size code
  localparam logic [2:0] VLMUL_MAX = 3'd3;

  // Register field positions inside cmd_payload_inputs_0
  localparam int REG_W   = 5;
  localparam int VD_LSB  = 0;
  localparam int VS0_LSB = 5;
  localparam int VS1_LSB = 10;

  // alu_mode position inside cmd_payload_function_id (low funct7 bits)
  localparam int ALU_MODE_LSB = 3;

  // Register numbers inside a group must have these low bits clear
  function automatic logic [REG_W-1:0] group_mask(input logic [2:0] vlmul);
    return REG_W'((6'd1 << vlmul) - 6'd1);
  endfunction

endpackage

// File: rtl/vcfu_sequencer.sv
// Multi-cycle command sequencer for the vector CFU datapath. Decodes CPU
// commands, steps IDLE -> EXEC -> WB -> RESP and drives register-file,
// BUS, ALU and write-back controls from latched command fields only.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. cmd_ready is high only in IDLE; rsp_valid is high only in
// RESP and the response word is held stable until rsp_ready is seen.
module vcfu_sequencer
  import vcfu_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned MUL_LAT  = 2,
  parameter logic [31:0] ERR_RESP = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  input  logic [7:0]  acc_in,
  output logic [4:0]  reg_op0_sel,
  output logic [4:0]  reg_op1_sel,
  output logic [4:0]  reg_wb_sel,
  output logic        reg_load,
  output logic [1:0]  bus_sel,
  output logic [1:0]  alu_mode,
  output logic        alu_op1_sel,
  output logic [7:0]  alu_imm,
  output logic [2:0]  vlmul,
  output logic [1:0]  dbg_state
);

  localparam int unsigned LAT_MAX = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rsp_q, rsp_d;
  logic [2:0]         vlmul_q, vlmul_d;
  logic [2:0]         op_q;
  logic [REG_W-1:0]   vd_q, vs0_q, vs1_q;
  logic [1:0]         mode_q;
  logic [7:0]         imm_q;

  // Live payload decode, only consulted on the accept edge
  logic               accept;
  logic [2:0]         in_f3;
  logic [2:0]         in_vset_code;
  logic [REG_W-1:0]   in_vd, in_vs0, in_vs1;
  logic               misaligned;
  logic               unused_bits;

  assign accept       = cmd_valid && (state_q == ST_IDLE);
  assign in_f3        = cmd_payload_function_id[2:0];
  assign in_vset_code = cmd_payload_inputs_0[2:0];
  assign in_vd        = cmd_payload_inputs_0[VD_LSB  +: REG_W];
  assign in_vs0       = cmd_payload_inputs_0[VS0_LSB +: REG_W];
  assign in_vs1       = cmd_payload_inputs_0[VS1_LSB +: REG_W];
  // vs1 is not a register operand for the immediate form
  assign misaligned   = |((in_vd | in_vs0 | ((in_f3 == OP_ALU_VI) ? '0 : in_vs1))
                          & group_mask(vlmul_q));
  assign unused_bits  = ^{cmd_payload_function_id[9:5],
                          cmd_payload_inputs_0[31:15],
                          cmd_payload_inputs_1[31:8]};

  assign vlmul     = vlmul_q;
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Latency counter, response word, vlmul and latched command fields
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rsp_q   <= '0;
      vlmul_q <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      vs0_q   <= '0;
      vs1_q   <= '0;
      mode_q  <= '0;
      imm_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      vlmul_q <= vlmul_d;
      if (accept) begin
        op_q   <= in_f3;
        vd_q   <= in_vd;
        vs0_q  <= in_vs0;
        vs1_q  <= in_vs1;
        mode_q <= cmd_payload_function_id[ALU_MODE_LSB +: 2];
        imm_q  <= cmd_payload_inputs_1[7:0];
      end
    end
  end

  // Next-state, counter/response updates and datapath controls
  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    rsp_d                 = rsp_q;
    vlmul_d               = vlmul_q;
    cmd_ready             = 1'b0;
    rsp_valid             = 1'b0;
    rsp_payload_outputs_0 = '0;
    reg_op0_sel           = '0;
    reg_op1_sel           = '0;
    reg_wb_sel            = '0;
    reg_load              = 1'b0;
    bus_sel               = BUS_NONE;
    alu_mode              = '0;
    alu_op1_sel           = 1'b0;
    alu_imm               = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (in_f3)
            OP_VSET: begin
              state_d = ST_RESP;
              if (in_vset_code <= VLMUL_MAX) begin
                vlmul_d = in_vset_code;
                rsp_d   = 32'd1 << in_vset_code;
              end else begin
                rsp_d   = ERR_RESP;
              end
            end
            OP_ALU_VV, OP_ALU_VI, OP_VMUL: begin
              if (misaligned) begin
                state_d = ST_RESP;
                rsp_d   = ERR_RESP;
              end else begin
                state_d = ST_EXEC;
                cnt_d   = (in_f3 == OP_VMUL) ? MUL_CNT : ALU_CNT;
                rsp_d   = '0;
              end
            end
            OP_VREDSUM: begin
              state_d = ST_EXEC;
              cnt_d   = ALU_CNT;
              rsp_d   = '0;
            end
            OP_NOP: begin
              state_d = ST_RESP;
              rsp_d   = '0;
            end
            default: begin
              state_d = ST_RESP;
              rsp_d   = ERR_RESP;
            end
          endcase
        end
      end

      ST_EXEC, ST_WB: begin
        reg_op0_sel = vs0_q;
        reg_op1_sel = vs1_q;
        alu_mode    = mode_q;
        alu_op1_sel = (op_q == OP_ALU_VI);
        alu_imm     = imm_q;
        case (op_q)
          OP_ALU_VV, OP_ALU_VI: bus_sel = BUS_ALU;
          OP_VMUL:              bus_sel = BUS_MUL;
          OP_VREDSUM:           bus_sel = BUS_ACC;
          default:              bus_sel = BUS_NONE;
        endcase
        if (state_q == ST_EXEC) begin
          if (cnt_q == CNT_ONE) begin
            if (op_q == OP_VREDSUM) begin
              state_d = ST_RESP;
              rsp_d   = {24'b0, acc_in};
            end else begin
              state_d = ST_WB;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          reg_wb_sel = vd_q;
          reg_load   = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid             = 1'b1;
        rsp_payload_outputs_0 = rsp_q;
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vcfu_sequencer.sv
// Directed bench for vcfu_sequencer at default parameters. Inputs are
// driven and outputs sampled on the falling edge; cycle N means the
// interval after the Nth rising edge counted from the accept edge (N=1).
module tb_vcfu_sequencer;
  import vcfu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic [7:0]  acc_in;
  logic [4:0]  reg_op0_sel;
  logic [4:0]  reg_op1_sel;
  logic [4:0]  reg_wb_sel;
  logic        reg_load;
  logic [1:0]  bus_sel;
  logic [1:0]  alu_mode;
  logic        alu_op1_sel;
  logic [7:0]  alu_imm;
  logic [2:0]  vlmul;
  logic [1:0]  dbg_state;

  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  vcfu_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .acc_in                  (acc_in),
    .reg_op0_sel             (reg_op0_sel),
    .reg_op1_sel             (reg_op1_sel),
    .reg_wb_sel              (reg_wb_sel),
    .reg_load                (reg_load),
    .bus_sel                 (bus_sel),
    .alu_mode                (alu_mode),
    .alu_op1_sel             (alu_op1_sel),
    .alu_imm                 (alu_imm),
    .vlmul                   (vlmul),
    .dbg_state               (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // driver: offer one command and leave the bench in cycle 1
  task automatic send(input logic [2:0] f3, input logic [1:0] mode,
                      input logic [4:0] vd, input logic [4:0] vs0,
                      input logic [4:0] vs1, input logic [31:0] in1);
    cmd_payload_function_id = {5'b0, mode, f3};
    cmd_payload_inputs_0    = {17'b0, vs1, vs0, vd};
    cmd_payload_inputs_1    = in1;
    cmd_valid               = 1'b1;
    check("cmd_ready_at_offer", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // scoreboard: compare the held response with the queue head, then take it
  task automatic take_rsp(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) check({tag, "_exp_empty"}, 32'd0, 32'd1);
    else check({tag, "_payload"}, rsp_payload_outputs_0, exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  // bounded wait for rsp_valid from cycle 'start', then check latency
  task automatic wait_rsp(input string tag, input int start, input int exp_lat);
    int n = start;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    take_rsp(tag);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    rsp_ready = 1'b0;
    acc_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_vlmul",     32'(vlmul),     32'd0);
    check("rst_reg_load",  32'(reg_load),  32'd0);
    check("rst_bus_sel",   32'(bus_sel),   32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));

    // VSET 2 -> response 4 in cycle 1, vlmul visible immediately after
    exp_q.push_back(32'd4);
    send(OP_VSET, 2'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    check("vset2_vlmul", 32'(vlmul), 32'd2);
    wait_rsp("vset2", 1, 1);
    check("vset2_vlmul_kept", 32'(vlmul), 32'd2);

    exp_q.push_back(32'd1);
    send(OP_VSET, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_rsp("vset0", 1, 1);

    // ALU_VV vd=3 vs0=1 vs1=2 mode=1
    exp_q.push_back(32'd0);
    send(OP_ALU_VV, 2'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    check("vv_c1_bus",      32'(bus_sel),     32'(BUS_ALU));
    check("vv_c1_op0",      32'(reg_op0_sel), 32'd1);
    check("vv_c1_op1",      32'(reg_op1_sel), 32'd2);
    check("vv_c1_mode",     32'(alu_mode),    32'd1);
    check("vv_c1_op1_sel",  32'(alu_op1_sel), 32'd0);
    check("vv_c1_reg_load", 32'(reg_load),    32'd0);
    check("vv_c1_rsp",      32'(rsp_valid),   32'd0);
    @(negedge clk);
    check("vv_c2_reg_load", 32'(reg_load),    32'd1);
    check("vv_c2_wb_sel",   32'(reg_wb_sel),  32'd3);
    check("vv_c2_bus",      32'(bus_sel),     32'(BUS_ALU));
    check("vv_c2_op0",      32'(reg_op0_sel), 32'd1);
    check("vv_c2_op1",      32'(reg_op1_sel), 32'd2);
    @(negedge clk);
    check("vv_c3_reg_load", 32'(reg_load),    32'd0);
    wait_rsp("alu_vv", 3, 3);

    // ALU_VI: immediate path, vs1 ignored
    exp_q.push_back(32'd0);
    send(OP_ALU_VI, 2'd2, 5'd5, 5'd6, 5'd31, 32'h0000_003C);
    check("vi_op1_sel", 32'(alu_op1_sel), 32'd1);
    check("vi_imm",     32'(alu_imm),     32'h3C);
    check("vi_mode",    32'(alu_mode),    32'd2);
    check("vi_bus",     32'(bus_sel),     32'(BUS_ALU));
    wait_rsp("alu_vi", 1, 3);

    // group alignment at vlmul=1
    exp_q.push_back(32'd2);
    send(OP_VSET, 2'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    wait_rsp("vset1", 1, 1);

    exp_q.push_back(ERR);
    send(OP_VMUL, 2'd0, 5'd3, 5'd4, 5'd6, 32'd0);
    check("mis_reg_load", 32'(reg_load),  32'd0);
    check("mis_bus",      32'(bus_sel),   32'd0);
    check("mis_state",    32'(dbg_state), 32'(ST_RESP));
    wait_rsp("vmul_mis", 1, 1);

    exp_q.push_back(32'd0);
    send(OP_ALU_VI, 2'd0, 5'd2, 5'd4, 5'd3, 32'h0000_0001);
    @(negedge clk);
    check("vi_odd_vs1_load", 32'(reg_load),   32'd1);
    check("vi_odd_vs1_wb",   32'(reg_wb_sel), 32'd2);
    wait_rsp("vi_odd_vs1", 2, 3);

    exp_q.push_back(ERR);
    send(OP_ALU_VV, 2'd0, 5'd2, 5'd4, 5'd3, 32'd0);
    wait_rsp("vv_odd_vs1", 1, 1);

    // VMUL with response back-pressure and a competing command
    exp_q.push_back(32'd0);
    send(OP_VMUL, 2'd0, 5'd2, 5'd4, 5'd6, 32'd0);
    check("mul_c1_bus",   32'(bus_sel),   32'(BUS_MUL));
    check("mul_c1_load",  32'(reg_load),  32'd0);
    check("mul_c1_state", 32'(dbg_state), 32'(ST_EXEC));
    @(negedge clk);
    check("mul_c2_bus",   32'(bus_sel),   32'(BUS_MUL));
    check("mul_c2_load",  32'(reg_load),  32'd0);
    @(negedge clk);
    check("mul_c3_load",  32'(reg_load),    32'd1);
    check("mul_c3_wb",    32'(reg_wb_sel),  32'd2);
    check("mul_c3_bus",   32'(bus_sel),     32'(BUS_MUL));
    check("mul_c3_op0",   32'(reg_op0_sel), 32'd4);
    check("mul_c3_op1",   32'(reg_op1_sel), 32'd6);
    @(negedge clk);
    cmd_payload_function_id = {7'b0, OP_VSET};
    cmd_payload_inputs_0    = 32'd3;
    cmd_valid               = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_payload",   rsp_payload_outputs_0, 32'd0);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_vlmul",     32'(vlmul),     32'd1);
      check("hold_reg_load",  32'(reg_load),  32'd0);
      @(negedge clk);
    end
    check("hold_payload_end", rsp_payload_outputs_0, exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_hs_vlmul",     32'(vlmul),     32'd1);
    check("post_hs_rsp",       32'(rsp_valid), 32'd0);
    exp_q.push_back(32'd8);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("late_vset_vlmul", 32'(vlmul), 32'd3);
    wait_rsp("late_vset3", 1, 1);

    // VSET with an illegal code keeps vlmul
    exp_q.push_back(ERR);
    send(OP_VSET, 2'd0, 5'd7, 5'd0, 5'd0, 32'd0);
    check("vset7_vlmul", 32'(vlmul), 32'd3);
    wait_rsp("vset7", 1, 1);

    exp_q.push_back(32'd1);
    send(OP_VSET, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_rsp("vset0b", 1, 1);

    // VREDSUM: accumulator byte captured in the last EXEC cycle
    acc_in = 8'hA5;
    exp_q.push_back(32'h0000_00A5);
    send(OP_VREDSUM, 2'd0, 5'd9, 5'd1, 5'd2, 32'd0);
    check("red_bus",   32'(bus_sel),     32'(BUS_ACC));
    check("red_load",  32'(reg_load),    32'd0);
    check("red_rsp",   32'(rsp_valid),   32'd0);
    check("red_op0",   32'(reg_op0_sel), 32'd1);
    @(negedge clk);
    acc_in = 8'h00;
    check("red_c2_load", 32'(reg_load), 32'd0);
    wait_rsp("vredsum", 2, 2);

    exp_q.push_back(32'd0);
    send(OP_NOP, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_rsp("nop", 1, 1);

    // reset during WB of a VMUL
    exp_q.push_back(32'd4);
    send(OP_VSET, 2'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    wait_rsp("vset2b", 1, 1);
    send(OP_VMUL, 2'd0, 5'd4, 5'd8, 5'd12, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("wbrst_in_wb", 32'(reg_load), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("wbrst_load",   32'(reg_load),  32'd0);
    check("wbrst_rsp",    32'(rsp_valid), 32'd0);
    check("wbrst_vlmul",  32'(vlmul),     32'd0);
    check("wbrst_state",  32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("wbrst_load_after", 32'(reg_load),  32'd0);
    check("wbrst_rsp_after",  32'(rsp_valid), 32'd0);
    exp_q.push_back(ERR);
    send(3'd7, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_rsp("f3_7", 1, 1);

    // reset during RESP discards the pending response
    send(OP_ALU_VV, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rsprst_pending", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rsprst_rsp",     32'(rsp_valid), 32'd0);
    check("rsprst_payload", rsp_payload_outputs_0, 32'd0);
    check("rsprst_state",   32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rsprst_rsp_after", 32'(rsp_valid), 32'd0);
    exp_q.push_back(ERR);
    send(3'd6, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_rsp("f3_6", 1, 1);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vcfu_sequencer.md
Name: vcfu_sequencer

Overview:
- Multi-cycle command sequencer for the vector CFU datapath: register file, ALU, multiplier and byte accumulator.
- Accepts CPU commands over the cmd/rsp handshake and decodes function_id and operands.
- Drives register-file selects, BUS mux select, ALU mode, immediate select and write-back strobe.
- Owns the vlmul configuration register.
- Replaces the trivial combinational handshake at the Cfu top level.

Parameters:
- ALU_LAT, 1, EXEC cycles for ALU ops (min 1).
- MUL_LAT, 2, EXEC cycles for multiply (min 1).
- ERR_RESP, 32'hFFFF_FFFF, response word for illegal/rejected commands.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept
- cmd_payload_function_id  in  10  [2:0]=funct3 opcode, [9:3]=funct7 (alu_mode in [4:3])
- cmd_payload_inputs_0  in  32  [4:0]=vd, [9:5]=vs0, [14:10]=vs1; config value for VSET
- cmd_payload_inputs_1  in  32  [7:0]=imm for ALU-immediate op
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU takes response
- rsp_payload_outputs_0  out  32  response word
- acc_in  in  8  byte accumulator result
- reg_op0_sel  out  5  source 0 register
- reg_op1_sel  out  5  source 1 register
- reg_wb_sel  out  5  destination register
- reg_load  out  1  register-file write strobe
- bus_sel  out  2  00 none, 01 ALU, 10 MUL, 11 ACC
- alu_mode  out  2  ALU function
- alu_op1_sel  out  1  1 = immediate into ALU op1
- alu_imm  out  8  latched immediate
- vlmul  out  3  register group size code

Behaviour:
- Single clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Command latched on the cmd_valid && cmd_ready edge. Datapath outputs come only from latched fields, never from live payload.
- Opcodes (funct3):
  - 0 VSET: vlmul <= inputs_0[2:0]. Legal codes 0..3; response = 1<<new vlmul.
  - 1 ALU_VV
  - 2 ALU_VI
  - 3 VMUL
  - 4 VREDSUM: bus_sel=11, no write; response {24'b0, acc_in}, sampled last EXEC cycle.
  - 5 NOP: response 0.
  - 6, 7: illegal.
- States: IDLE, EXEC, WB, RESP.
- IDLE:
  - cmd_ready=1, everything else 0; bus_sel=00.
  - On accept:
    - VSET, NOP and illegal go straight to RESP.
    - ALU_VV, ALU_VI, VMUL and VREDSUM go to EXEC with the latency counter loaded.
- EXEC:
  - op sels = vs0/vs1; bus_sel per op; alu_mode/alu_op1_sel held.
  - Counter decrements each cycle.
  - At count 1: VREDSUM goes to RESP; the others go to WB.
- WB:
  - reg_load=1 for exactly one cycle; reg_wb_sel=vd.
  - bus_sel and op sels held identical to EXEC, so BUS is stable through the write.
  - Next state RESP.
- RESP:
  - rsp_valid=1; payload held stable until rsp_ready.
  - rsp_valid && rsp_ready goes to IDLE. The next command can be accepted one cycle later, with no same-cycle accept.
  - Response for write ops = 0.
- Latency, accept edge to first rsp_valid cycle:
  - ALU: ALU_LAT+2 (3 at defaults).
  - VMUL: MUL_LAT+2 (4 at defaults).
  - VREDSUM: ALU_LAT+1.
  - VSET/NOP/illegal: 1.
- Group alignment: for ALU_VV, ALU_VI, VMUL, any of vd/vs0/vs1 with low vlmul bits nonzero gives ERR_RESP, no EXEC, no reg_load.
  - vs1 is ignored for ALU_VI.
- VSET with illegal code (4..7): vlmul unchanged, ERR_RESP.
- vlmul update is visible the cycle after accept. It never changes while a vector op is in flight.
- cmd_ready=0 in EXEC, WB and RESP; cmd_valid there is ignored and not latched.
- rsp_ready asserted outside RESP is ignored.
- Reset, including mid-operation:
  - Next edge: IDLE, vlmul=0, all outputs 0 except cmd_ready=1.
  - An in-flight write is dropped: no reg_load after reset.
  - A pending response is discarded.

Decomposition:
- Package vcfu_pkg:
  - funct3 opcode constants
  - state enum
  - bus_sel encodings (BUS_NONE/ALU/MUL/ACC)
  - VLMUL_MAX=3
  - field bit positions of vd/vs0/vs1
- The single module contains decode, FSM, latency counter and vlmul register; no sub-module is warranted.

Test Plan:
- Reset, then VSET inputs_0=2 -> rsp_valid 1 cycle after accept, payload 4; vlmul=2 thereafter.
- vlmul=0, ALU_VV vd=3 vs0=1 vs1=2 alu_mode=1:
  - bus_sel=01 in EXEC+WB.
  - Single reg_load pulse with reg_wb_sel=3 at cycle 2.
  - rsp_valid at cycle 3, payload 0.
- vlmul=1, VMUL vd=3 -> ERR_RESP at cycle 1, reg_load never asserted.
- VMUL with rsp_ready held low 5 cycles:
  - rsp_valid and payload stable.
  - cmd_ready=0 throughout; second cmd_valid ignored.
  - Accepted only after the rsp handshake.
- VREDSUM with acc_in=8'hA5 -> payload 32'h0000_00A5, bus_sel=11 during EXEC, no reg_load.
- reset asserted during WB of a VMUL, and separately during RESP:
  - Next cycle IDLE, reg_load=0, rsp_valid=0, vlmul=0.
  - Then funct3=7 -> ERR_RESP.
